// File: rtl/shapool_job_ctrl.sv
// shapool_job_ctrl: job loader and result collector wrapped around the shapool
// hashing pool. It shifts in a 47-byte job, releases the pool to run, then
// returns either the winning nonce counter or an exhaustion result over a
// valid/ready handshake.
module shapool_job_ctrl #(
    parameter  int POOL_SIZE_LOG2 = 0,
    localparam int NONCE_WIDTH    = 32 - POOL_SIZE_LOG2,
    localparam int JOB_BYTES      = 47
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   abort,
    output logic [255:0]           sha_state,
    output logic [95:0]            message_head,
    output logic [15:0]            difficulty_bm,
    output logic [7:0]             nonce_start_MSB,
    output logic                   pool_reset_n,
    input  logic                   pool_success,
    input  logic [NONCE_WIDTH-1:0] pool_nonce,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic                   result_found,
    output logic [NONCE_WIDTH-1:0] result_nonce,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [5:0]             r_byte_cnt;
    logic [8*JOB_BYTES-1:0] r_job_sr;
    logic [NONCE_WIDTH-1:0] r_prev_nonce;
    logic                   r_pool_reset_n;
    logic                   r_result_valid;
    logic                   r_result_found;
    logic [NONCE_WIDTH-1:0] r_result_nonce;

    logic w_accept;
    logic w_last_byte;
    logic w_wrap;

    // Handshake and end-of-space decode
    assign w_accept    = in_valid && in_ready;
    assign w_last_byte = (r_byte_cnt == 6'(JOB_BYTES - 1));
    // A wrap is seen only as all-ones followed by zero on consecutive RUN cycles
    assign w_wrap      = (r_prev_nonce == '1) && (pool_nonce == '0);

    // Field mapping: first byte received lands in the top of sha_state
    assign {sha_state, message_head, difficulty_bm, nonce_start_MSB} = r_job_sr;

    assign in_ready     = (r_state == S_LOAD);
    assign busy         = (r_state == S_RUN);
    assign pool_reset_n = r_pool_reset_n;
    assign result_valid = r_result_valid;
    assign result_found = r_result_found;
    assign result_nonce = r_result_nonce;

    // Control FSM: load job, run pool, hold result until consumed
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_LOAD;
            r_byte_cnt     <= '0;
            r_job_sr       <= '0;
            r_prev_nonce   <= '0;
            r_pool_reset_n <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_found <= 1'b0;
            r_result_nonce <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (abort) begin
                        // Restart counting but keep whatever bytes are already shifted in
                        r_byte_cnt <= '0;
                    end else if (w_accept) begin
                        r_job_sr <= {r_job_sr[8*JOB_BYTES-9:0], in_data};
                        if (w_last_byte) begin
                            r_byte_cnt     <= '0;
                            r_prev_nonce   <= '0;
                            r_pool_reset_n <= 1'b1;
                            r_state        <= S_RUN;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 6'd1;
                        end
                    end
                end
                S_RUN: begin
                    r_prev_nonce <= pool_nonce;
                    if (abort) begin
                        r_pool_reset_n <= 1'b0;
                        r_state        <= S_LOAD;
                    end else if (pool_success || w_wrap) begin
                        // Success outranks a same-cycle wrap
                        r_result_found <= pool_success;
                        r_result_nonce <= pool_nonce;
                        r_result_valid <= 1'b1;
                        r_pool_reset_n <= 1'b0;
                        r_state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        r_result_valid <= 1'b0;
                        r_state        <= S_LOAD;
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

endmodule
